// File: rtl/updown_counter_n.sv
// ---------------------------------------------------------------------------
// updown_counter_n
//
// Parametrised N-bit up/down counter with a programmable modulus
// (0..MAX_COUNT), synchronous load with clamping, count enable, and a choice
// of wrap-around or saturate behaviour at the range boundaries.
//
// Parameters
//   WIDTH      counter width in bits (>= 1)
//   MAX_COUNT  highest count value, must fit in WIDTH bits
//   SATURATE   0 = wrap at the boundaries, 1 = hold at the boundaries
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high reset
//   en     in   1      count enable; q holds when low
//   x      in   1      direction: 0 = up, 1 = down
//   load   in   1      synchronous load strobe (overrides en)
//   d      in   WIDTH  load value, clamped to MAX_COUNT
//   q      out  WIDTH  current count (registered)
//   l      out  1      terminal-count indicator, decoded from q and x
//   wrap   out  1      one-cycle registered pulse after a wrap-around edge
// ---------------------------------------------------------------------------
module updown_counter_n #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             l,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam bit               SAT  = (SATURATE != 0);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;

  // Next-state decode. Priority below reset: load > en > hold.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the if/else tree can leave it unassigned and infer a latch.
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;

    if (load) begin
      // Clamp keeps q inside 0..MAX_COUNT no matter what d carries.
      w_q_next = (d > MAX) ? MAX : d;
    end else if (en) begin
      if (!x) begin
        if (r_q < MAX) begin
          w_q_next = r_q + ONE;
        end else begin
          // q == MAX (or an out-of-range value): wrap to 0 or pin at MAX.
          w_q_next    = SAT ? MAX : ZERO;
          w_wrap_next = !SAT;
        end
      end else begin
        if (r_q != ZERO) begin
          w_q_next = r_q - ONE;
        end else begin
          w_q_next    = SAT ? ZERO : MAX;
          w_wrap_next = !SAT;
        end
      end
    end
  end

  // State register with synchronous reset; reset also drops a pending wrap.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  // Terminal count depends on the live direction input, so a change on x
  // is reflected on l without waiting for a clock edge.
  assign l    = x ? (r_q == ZERO) : (r_q == MAX);
  assign q    = r_q;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_updown_counter_n.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_n
//
// Directed bench for updown_counter_n. Three instances share one stimulus
// stream: the default wrap configuration, a saturating configuration and a
// small 2-bit/modulus-4 configuration. Each phase starts from a reset so the
// instance under scrutiny has a known state.
// ---------------------------------------------------------------------------
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       x;
  logic       load;
  logic [3:0] d;

  logic [3:0] q0, q1;
  logic [1:0] q2;
  logic       l0, l1, l2;
  logic       w0, w1, w2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .d(d),
    .q(q0), .l(l0), .wrap(w0)
  );

  updown_counter_n #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .d(d),
    .q(q1), .l(l1), .wrap(w1)
  );

  updown_counter_n #(.WIDTH(2), .MAX_COUNT(3), .SATURATE(0)) u_small (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .d(d[1:0]),
    .q(q2), .l(l2), .wrap(w2)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    x     = 1'b0;
    load  = 1'b0;
    d     = '0;
    #2;

    // ---- Reset --------------------------------------------------------
    tick(2);
    check("rst_q",    q0, 0);
    check("rst_wrap", w0, 0);
    check("rst_l_up", l0, 0);
    x = 1'b1;
    #1;
    check("rst_l_dn_noclk", l0, 1);

    // ---- Up count and wrap -------------------------------------------
    x     = 1'b0;
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("up_q%0d", k), q0, k);
      check($sformatf("up_l%0d", k), l0, (k == 9) ? 1 : 0);
      check($sformatf("up_w%0d", k), w0, 0);
    end
    tick();
    check("up_wrap_q", q0, 0);
    check("up_wrap_w", w0, 1);
    tick();
    check("up_after_q", q0, 1);
    check("up_after_w", w0, 0);

    // ---- Down wrap and direction flip --------------------------------
    tick();
    check("pre_dn_q", q0, 2);
    x = 1'b1;
    #1;
    check("dn_l_at2", l0, 0);
    tick();
    check("dn_q1", q0, 1);
    check("dn_w1", w0, 0);
    tick();
    check("dn_q0", q0, 0);
    check("dn_l0", l0, 1);
    check("dn_w0", w0, 0);
    tick();
    check("dn_wrap_q", q0, 9);
    check("dn_wrap_w", w0, 1);
    x = 1'b0;
    tick();
    check("flip_q", q0, 0);
    check("flip_w", w0, 1);

    // ---- Load and clamp ----------------------------------------------
    load = 1'b1;
    d    = 4'd7;
    tick();
    check("ld7_q", q0, 7);
    check("ld7_w", w0, 0);
    d = 4'd14;
    tick();
    check("ld14_clamp_q", q0, 9);
    d = 4'd3;
    tick();
    check("ld_over_en_q", q0, 3);
    load = 1'b0;
    en   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold_q%0d", k), q0, 3);
      check($sformatf("hold_w%0d", k), w0, 0);
    end

    // ---- Reset drops a pending wrap ----------------------------------
    en    = 1'b1;
    load  = 1'b1;
    d     = 4'd9;
    tick();
    load  = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_drop_q", q0, 0);
    check("rst_drop_w", w0, 0);

    // ---- Saturate ----------------------------------------------------
    reset = 1'b0;
    x     = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("sat_up_q%0d", k), q1, (k < 9) ? k : 9);
      check($sformatf("sat_up_w%0d", k), w1, 0);
    end
    check("sat_up_l", l1, 1);
    x = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("sat_dn_q%0d", k), q1, (k < 9) ? 9 - k : 0);
      check($sformatf("sat_dn_w%0d", k), w1, 0);
    end
    check("sat_dn_l", l1, 1);

    // ---- Small config: WIDTH=2, MAX_COUNT=3 --------------------------
    reset = 1'b1;
    x     = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("sm_q1", q2, 1);
    tick();
    check("sm_q2", q2, 2);
    tick();
    check("sm_q3", q2, 3);
    check("sm_l3", l2, 1);
    check("sm_w3", w2, 0);
    tick();
    check("sm_wrap_q", q2, 0);
    check("sm_wrap_w", w2, 1);
    tick();
    check("sm_q_after", q2, 1);
    reset = 1'b1;
    load  = 1'b1;
    d     = 4'd2;
    tick();
    check("sm_rst_vs_load_q", q2, 0);
    check("sm_rst_vs_load_w", w2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
